decode_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/decode_stage_regfile.sv | 45 ++++
 rtl/decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_decode_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 16-bit pipelined CPU: opcode and ALU op
// encodings, register-file geometry and the decoded-instruction payload.
package cpu_pkg;

  localparam int unsigned XLEN   = 16;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned ALU_W  = 4;
  localparam int unsigned BC_W   = 6;

  typedef enum logic [OPC_W-1:0] {
    OP_ALU  = 3'd0,
    OP_ADDI = 3'd1,
    OP_LUI  = 3'd2,
    OP_SW   = 3'd3,
    OP_LW   = 3'd4,
    OP_BR   = 3'd5,
    OP_JALR = 3'd6,
    OP_SYS  = 3'd7
  } opcode_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NAND = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7
  } alu_op_e;

  // Fields extracted from one instruction word.
  typedef struct packed {
    opcode_e           opcode;
    logic [REG_AW-1:0] tgt;
    logic [REG_AW-1:0] s1;
    logic [REG_AW-1:0] s2;
    alu_op_e           alu_op;
    logic [XLEN-1:0]   imm;
    logic [BC_W-1:0]   branch_code;
    logic              halt;
  } dec_t;

  // Sign-extend the 7-bit immediate to the data width.
  function automatic logic [XLEN-1:0] sext7(input logic [6:0] v);
    return {{(XLEN-7){v[6]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 8x16 register file for the decode stage.
//   clk, rst               clock, async active-high reset (all regs clear)
//   we, wr_addr, wr_data   write port, committed on the rising edge
//   rd_addr_a/b            read addresses
//   rd_data_a_c/b_c        combinational read data with write-through
//   r1                     live contents of r1 (program return value)
module regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [XLEN-1:0]   rd_data_a_c,
  output logic [XLEN-1:0]   rd_data_b_c,
  output logic [XLEN-1:0]   r1
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage; r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: r0 reads zero, a same-cycle write to the source bypasses storage.
  always_comb begin
    rd_data_a_c = regs[rd_addr_a];
    rd_data_b_c = regs[rd_addr_b];
    if (rd_addr_a == '0)                    rd_data_a_c = '0;
    else if (we && (wr_addr == rd_addr_a))  rd_data_a_c = wr_data;
    if (rd_addr_b == '0)                    rd_data_b_c = '0;
    else if (we && (wr_addr == rd_addr_b))  rd_data_b_c = wr_data;
  end

  assign r1 = regs[1];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode stage of the five-stage 16-bit CPU.
// Splits the fetched instruction into fields, reads operands from the
// register file, and detects load-use hazards (stall toward fetch).
//   clk, rst                         clock, async active-high reset
//   flush                            squash the instruction in decode
//   instr_in, bubble_in, pc_in       fetched instruction, invalid flag, PC
//   reg_we, reg_tgt, reg_write_data  writeback port
//   op1_out, op2_out                 operand values of s_1 / s_2
//   pc_out, opcode_out, s_1_out, s_2_out, tgt_out, alu_op_out,
//   imm_out, branch_code_out         registered decoded fields
//   bubble_out, halt_out             registered validity / halt
//   stall                            combinational hold request to fetch
//   ret_val                          live contents of r1
module decode_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [XLEN-1:0]   instr_in,
  input  logic              bubble_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] reg_tgt,
  input  logic [XLEN-1:0]   reg_write_data,
  output logic [XLEN-1:0]   op1_out,
  output logic [XLEN-1:0]   op2_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [OPC_W-1:0]  opcode_out,
  output logic [REG_AW-1:0] s_1_out,
  output logic [REG_AW-1:0] s_2_out,
  output logic [REG_AW-1:0] tgt_out,
  output logic [ALU_W-1:0]  alu_op_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [BC_W-1:0]   branch_code_out,
  output logic              bubble_out,
  output logic              stall,
  output logic              halt_out,
  output logic [XLEN-1:0]   ret_val
);

  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic [XLEN-1:0] cur_instr;
  logic [XLEN-1:0] cur_pc;
  logic            cur_valid;
  dec_t            dec;
  logic [XLEN-1:0] op1_c;
  logic [XLEN-1:0] op2_c;
  logic            kill_c;

  // A held (stalled) instruction takes precedence over the fetch inputs.
  always_comb begin
    cur_instr = instr_in;
    cur_pc    = pc_in;
    cur_valid = !bubble_in;
    if (hold_valid) begin
      cur_instr = hold_instr;
      cur_pc    = hold_pc;
      cur_valid = 1'b1;
    end
  end

  // Field extraction by opcode; unlisted fields stay zero, alu_op defaults to ADD.
  always_comb begin
    dec        = '0;
    dec.opcode = opcode_e'(cur_instr[15:13]);
    dec.alu_op = ALU_ADD;
    case (dec.opcode)
      OP_ALU: begin
        dec.tgt    = cur_instr[12:10];
        dec.s1     = cur_instr[9:7];
        dec.s2     = cur_instr[2:0];
        dec.alu_op = alu_op_e'(cur_instr[6:3]);
      end
      OP_ADDI, OP_LW, OP_JALR: begin
        dec.tgt = cur_instr[12:10];
        dec.s1  = cur_instr[9:7];
        dec.imm = sext7(cur_instr[6:0]);
      end
      OP_LUI: begin
        dec.tgt = cur_instr[12:10];
        dec.imm = {cur_instr[9:0], 6'b0};
      end
      OP_SW: begin
        dec.s1  = cur_instr[9:7];
        dec.s2  = cur_instr[12:10];
        dec.imm = sext7(cur_instr[6:0]);
      end
      OP_BR: begin
        dec.branch_code = cur_instr[12:7];
        dec.imm         = sext7(cur_instr[6:0]);
      end
      OP_SYS: begin
        dec.imm  = {3'b0, cur_instr[12:0]};
        dec.halt = (cur_instr[12:0] == 13'd0);
      end
      default: ;
    endcase
  end

  regfile u_regfile (
    .clk         (clk),
    .rst         (rst),
    .we          (reg_we),
    .wr_addr     (reg_tgt),
    .wr_data     (reg_write_data),
    .rd_addr_a   (dec.s1),
    .rd_addr_b   (dec.s2),
    .rd_data_a_c (op1_c),
    .rd_data_b_c (op2_c),
    .r1          (ret_val)
  );

  // Load-use: the load now in execute writes a register this instruction reads.
  // Source index 0 can never match since tgt_out is required nonzero.
  assign stall = cur_valid && !flush && !bubble_out
              && (opcode_out == 3'(OP_LW)) && (tgt_out != '0)
              && ((tgt_out == dec.s1) || (tgt_out == dec.s2));

  assign kill_c = flush || stall || !cur_valid;

  // Hold register: capture on stall, release once issued or flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (stall) begin
      hold_valid <= 1'b1;
      hold_instr <= cur_instr;
      hold_pc    <= cur_pc;
    end else begin
      hold_valid <= 1'b0;
    end
  end

  // Decode/execute pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_out         <= '0;
      op2_out         <= '0;
      pc_out          <= '0;
      opcode_out      <= '0;
      s_1_out         <= '0;
      s_2_out         <= '0;
      tgt_out         <= '0;
      alu_op_out      <= '0;
      imm_out         <= '0;
      branch_code_out <= '0;
      bubble_out      <= 1'b1;
      halt_out        <= 1'b0;
    end else begin
      op1_out         <= op1_c;
      op2_out         <= op2_c;
      pc_out          <= cur_pc;
      opcode_out      <= dec.opcode;
      alu_op_out      <= dec.alu_op;
      imm_out         <= dec.imm;
      branch_code_out <= dec.branch_code;
      if (kill_c) begin
        bubble_out <= 1'b1;
        halt_out   <= 1'b0;
        tgt_out    <= '0;
        s_1_out    <= '0;
        s_2_out    <= '0;
      end else begin
        bubble_out <= 1'b0;
        halt_out   <= dec.halt;
        tgt_out    <= dec.tgt;
        s_1_out    <= dec.s1;
        s_2_out    <= dec.s2;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the decode stage.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [15:0] instr_in;
  logic        bubble_in;
  logic [15:0] pc_in;
  logic        reg_we;
  logic [2:0]  reg_tgt;
  logic [15:0] reg_write_data;
  logic [15:0] op1_out, op2_out, pc_out, imm_out, ret_val;
  logic [2:0]  opcode_out, s_1_out, s_2_out, tgt_out;
  logic [3:0]  alu_op_out;
  logic [5:0]  branch_code_out;
  logic        bubble_out, stall, halt_out;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_in(instr_in), .bubble_in(bubble_in), .pc_in(pc_in),
    .reg_we(reg_we), .reg_tgt(reg_tgt), .reg_write_data(reg_write_data),
    .op1_out(op1_out), .op2_out(op2_out), .pc_out(pc_out),
    .opcode_out(opcode_out), .s_1_out(s_1_out), .s_2_out(s_2_out),
    .tgt_out(tgt_out), .alu_op_out(alu_op_out), .imm_out(imm_out),
    .branch_code_out(branch_code_out), .bubble_out(bubble_out),
    .stall(stall), .halt_out(halt_out), .ret_val(ret_val)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [15:0] m_regs [8];
  logic        m_hv;
  logic [15:0] m_hi, m_hp;
  logic        e_bubble, e_halt;
  logic [2:0]  e_op, e_tgt, e_s1, e_s2;
  logic [3:0]  e_alu;
  logic [15:0] e_imm, e_op1, e_op2, e_pc;
  logic [5:0]  e_bc;
  logic        m_stall;    // model stall of the last cycle
  logic        dut_stall;  // stall observed in the last cycle

  function automatic logic [15:0] m_sext7(input logic [15:0] i);
    int v;
    v = int'(i[6:0]);
    if (v >= 64) v = v - 128;
    return 16'(v);
  endfunction

  // Instruction semantics from the ISA table.
  function automatic void m_decode(input logic [15:0] i,
      output logic [2:0] op, output logic [2:0] tg, output logic [2:0] s1,
      output logic [2:0] s2, output logic [3:0] al, output logic [15:0] im,
      output logic [5:0] bc, output logic hl);
    logic [2:0] ra, rb, rc;
    op = i[15:13]; ra = i[12:10]; rb = i[9:7]; rc = i[2:0];
    tg = 0; s1 = 0; s2 = 0; al = 0; im = 0; bc = 0; hl = 0;
    if (op == 0) begin tg = ra; s1 = rb; s2 = rc; al = i[6:3]; end
    else if (op == 1 || op == 4 || op == 6) begin tg = ra; s1 = rb; im = m_sext7(i); end
    else if (op == 2) begin tg = ra; im = 16'(32'(i[9:0]) * 64); end
    else if (op == 3) begin s1 = rb; s2 = ra; im = m_sext7(i); end
    else if (op == 5) begin bc = i[12:7]; im = m_sext7(i); end
    else begin im = 16'(i[12:0]); hl = (i[12:0] == 13'd0); end
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a, input logic we,
      input logic [2:0] wt, input logic [15:0] wd);
    if (a == 0) return 16'h0;
    if (we && wt == a) return wd;
    return m_regs[a];
  endfunction

  // One clock: drive inputs, check stall before the edge, outputs after it.
  task automatic run_cycle(input logic [15:0] ins, input logic bub, input logic [15:0] pc,
      input logic fl, input logic we, input logic [2:0] wt, input logic [15:0] wd);
    logic [15:0] ci, cp, im;
    logic        cv, hl;
    logic [2:0]  op, tg, s1, s2;
    logic [3:0]  al;
    logic [5:0]  bc;
    instr_in = ins; bubble_in = bub; pc_in = pc; flush = fl;
    reg_we = we; reg_tgt = wt; reg_write_data = wd;
    #1;
    ci = m_hv ? m_hi : ins;
    cp = m_hv ? m_hp : pc;
    cv = m_hv || !bub;
    m_decode(ci, op, tg, s1, s2, al, im, bc, hl);
    m_stall = cv && !fl && !e_bubble && e_op == 3'd4 && e_tgt != 0
           && (e_tgt == s1 || e_tgt == s2);
    dut_stall = stall;
    check("stall", {31'b0, stall}, {31'b0, m_stall});
    @(posedge clk);
    if (fl || m_stall || !cv) begin
      e_bubble = 1; e_halt = 0; e_tgt = 0; e_s1 = 0; e_s2 = 0;
    end else begin
      e_bubble = 0; e_halt = hl; e_tgt = tg; e_s1 = s1; e_s2 = s2;
      e_op = op; e_alu = al; e_imm = im; e_bc = bc; e_pc = cp;
      e_op1 = m_read(s1, we, wt, wd);
      e_op2 = m_read(s2, we, wt, wd);
    end
    if (fl)           m_hv = 0;
    else if (m_stall) begin m_hv = 1; m_hi = ci; m_hp = cp; end
    else              m_hv = 0;
    if (we && wt != 0) m_regs[wt] = wd;
    #1;
    check("bubble_out", {31'b0, bubble_out}, {31'b0, e_bubble});
    check("halt_out", {31'b0, halt_out}, {31'b0, e_halt});
    check("tgt_out", {29'b0, tgt_out}, {29'b0, e_tgt});
    check("s_1_out", {29'b0, s_1_out}, {29'b0, e_s1});
    check("s_2_out", {29'b0, s_2_out}, {29'b0, e_s2});
    check("ret_val", {16'b0, ret_val}, {16'b0, m_regs[1]});
    if (!e_bubble) begin
      check("opcode_out", {29'b0, opcode_out}, {29'b0, e_op});
      check("alu_op_out", {28'b0, alu_op_out}, {28'b0, e_alu});
      check("imm_out", {16'b0, imm_out}, {16'b0, e_imm});
      check("branch_code_out", {26'b0, branch_code_out}, {26'b0, e_bc});
      check("op1_out", {16'b0, op1_out}, {16'b0, e_op1});
      check("op2_out", {16'b0, op2_out}, {16'b0, e_op2});
      check("pc_out", {16'b0, pc_out}, {16'b0, e_pc});
    end
  endtask

  initial begin
    logic [15:0] r_ins, r_pc;
    logic        r_bub;
    clk = 0; rst = 1; flush = 0; instr_in = 0; bubble_in = 1; pc_in = 0;
    reg_we = 0; reg_tgt = 0; reg_write_data = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_hv = 0; m_hi = 0; m_hp = 0; m_stall = 0; dut_stall = 0;
    e_bubble = 1; e_halt = 0; e_op = 0; e_tgt = 0; e_s1 = 0; e_s2 = 0;
    e_alu = 0; e_imm = 0; e_op1 = 0; e_op2 = 0; e_pc = 0; e_bc = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_bubble", {31'b0, bubble_out}, 32'd1);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_ret_val", {16'b0, ret_val}, 32'd0);
    check("rst_op1", {16'b0, op1_out}, 32'd0);
    rst = 0;

    // r1 = 5, then ADDI r2,r1,3
    run_cycle(16'h0000, 1, 16'h0000, 0, 1, 3'd1, 16'd5);
    run_cycle(16'h2883, 0, 16'h0010, 0, 0, 3'd0, 16'd0);
    check("addi_ret_val", {16'b0, ret_val}, 32'd5);
    check("addi_opcode", {29'b0, opcode_out}, 32'd1);
    check("addi_tgt", {29'b0, tgt_out}, 32'd2);
    check("addi_s1", {29'b0, s_1_out}, 32'd1);
    check("addi_op1", {16'b0, op1_out}, 32'd5);
    check("addi_imm", {16'b0, imm_out}, 32'd3);

    // write-through on both operands
    run_cycle(16'h15B3, 0, 16'h0011, 0, 1, 3'd3, 16'h1234);
    check("wt_op1", {16'b0, op1_out}, 32'h1234);
    check("wt_op2", {16'b0, op2_out}, 32'h1234);

    // load-use with fetch holding the dependent instruction
    run_cycle(16'h9080, 0, 16'h0020, 0, 0, 3'd0, 16'd0);
    run_cycle(16'h1604, 0, 16'h0021, 0, 0, 3'd0, 16'd0);
    check("lu_stall", {31'b0, dut_stall}, 32'd1);
    check("lu_bubble", {31'b0, bubble_out}, 32'd1);
    run_cycle(16'h1604, 0, 16'h0021, 0, 0, 3'd0, 16'd0);
    check("lu_stall_once", {31'b0, dut_stall}, 32'd0);
    check("lu_issue", {31'b0, bubble_out}, 32'd0);
    check("lu_s1", {29'b0, s_1_out}, 32'd4);
    check("lu_s2", {29'b0, s_2_out}, 32'd4);

    // flush in the would-be stall cycle
    run_cycle(16'h9080, 0, 16'h0030, 0, 0, 3'd0, 16'd0);
    run_cycle(16'h1604, 0, 16'h0031, 1, 0, 3'd0, 16'd0);
    check("fl_stall", {31'b0, dut_stall}, 32'd0);
    check("fl_bubble", {31'b0, bubble_out}, 32'd1);
    run_cycle(16'h1604, 1, 16'h0031, 0, 0, 3'd0, 16'd0);
    check("fl_hold_empty", {31'b0, bubble_out}, 32'd1);

    // halt, and r0 stays zero
    run_cycle(16'hE000, 0, 16'h0040, 0, 0, 3'd0, 16'd0);
    check("sys_halt", {31'b0, halt_out}, 32'd1);
    run_cycle(16'h2800, 0, 16'h0041, 0, 1, 3'd0, 16'hFFFF);
    check("r0_wt_op1", {16'b0, op1_out}, 32'd0);
    run_cycle(16'h2800, 0, 16'h0042, 0, 0, 3'd0, 16'd0);
    check("r0_op1", {16'b0, op1_out}, 32'd0);

    // random traffic; fetch repeats its instruction after a stall
    r_ins = 0; r_pc = 16'h0100; r_bub = 1;
    for (int c = 0; c < 600; c++) begin
      if (!m_stall) begin
        r_ins = 16'($urandom);
        if ($urandom_range(0, 3) == 0) r_ins[15:13] = 3'd4;
        r_bub = ($urandom_range(0, 6) == 0);
        r_pc  = r_pc + 16'd1;
      end
      run_cycle(r_ins, r_bub, r_pc, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
